// File: rtl/tablero_pkg.sv
// Shared constants, board types and FSM state encoding for the board writer.
package tablero_pkg;

  localparam int ROWS   = 5;
  localparam int COLS   = 5;
  localparam int CELL_W = 8;
  localparam int IDX_W  = 3;

  localparam logic [CELL_W-1:0] CLEAR_VAL = 8'h00;

  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(COLS - 1);

  typedef logic [CELL_W-1:0] cell_t;
  typedef cell_t [0:ROWS-1][0:COLS-1] board_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2
  } estado_t;

  function automatic logic in_range(input logic [IDX_W-1:0] row,
                                    input logic [IDX_W-1:0] col);
    return (int'(row) < ROWS) && (int'(col) < COLS);
  endfunction

endpackage

// File: rtl/tablero_idx_cnt.sv
// Row-major cell cursor shared by the clear sweep and the streamed load.
module tablero_idx_cnt
  import tablero_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  assign last = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tablero_carga.sv
// Board writer: holds the ROWS x COLS cell matrix and fills it by stream load,
// single-cell writes or a one-cell-per-cycle clear sweep.
module tablero_carga
  import tablero_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_req,
  input  logic             load_start,
  input  logic             cell_valid,
  input  logic [CELL_W-1:0] cell_data,
  output logic             cell_ready,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_row,
  input  logic [IDX_W-1:0] wr_col,
  input  logic [CELL_W-1:0] wr_data,
  output board_t           matriz,
  output logic             busy,
  output logic             done,
  output logic             wr_err
);

  estado_t          state;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_last;
  logic [IDX_W-1:0] cnt_row;
  logic [IDX_W-1:0] cnt_col;

  logic             w_en;
  logic [IDX_W-1:0] w_row;
  logic [IDX_W-1:0] w_col;
  cell_t            w_data;
  logic             wr_ok;

  tablero_idx_cnt u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .row   (cnt_row),
    .col   (cnt_col),
    .last  (cnt_last)
  );

  // Single write port into the matrix; the source depends on the state.
  always_comb begin
    w_en    = 1'b0;
    w_row   = cnt_row;
    w_col   = cnt_col;
    w_data  = CLEAR_VAL;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    wr_ok   = 1'b0;
    case (state)
      IDLE: begin
        wr_ok   = wr_en && !clear_req && !load_start && in_range(wr_row, wr_col);
        w_en    = wr_ok;
        w_row   = wr_row;
        w_col   = wr_col;
        w_data  = wr_data;
        cnt_clr = clear_req || load_start;
      end
      CLEAR: begin
        w_en    = 1'b1;
        cnt_inc = 1'b1;
      end
      LOAD: begin
        if (clear_req) begin
          cnt_clr = 1'b1;
        end else if (cell_valid) begin
          w_en    = 1'b1;
          w_data  = cell_data;
          cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matriz <= board_t'({ROWS * COLS{CLEAR_VAL}});
    end else if (w_en) begin
      matriz[w_row][w_col] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cell_ready <= 1'b0;
      done       <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      done   <= 1'b0;
      wr_err <= wr_en && !wr_ok;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            busy  <= 1'b1;
          end else if (load_start) begin
            state      <= LOAD;
            busy       <= 1'b1;
            cell_ready <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        LOAD: begin
          // An abort hands over to the sweep without signalling completion.
          if (clear_req) begin
            state      <= CLEAR;
            cell_ready <= 1'b0;
          end else if (cell_valid && cnt_last) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cell_ready <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          cell_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tablero_carga.sv
// Directed bench for tablero_carga: vector table for idle writes plus load/clear sequences.
module tb_tablero_carga;
  import tablero_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear_req = 1'b0;
  logic             load_start = 1'b0;
  logic             cell_valid = 1'b0;
  cell_t            cell_data = '0;
  logic             cell_ready;
  logic             wr_en = 1'b0;
  logic [IDX_W-1:0] wr_row = '0;
  logic [IDX_W-1:0] wr_col = '0;
  cell_t            wr_data = '0;
  board_t           matriz;
  logic             busy;
  logic             done;
  logic             wr_err;

  int     n_cmp = 0;
  int     n_bad = 0;
  board_t exp_b;

  typedef struct {
    logic             en;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    cell_t            data;
    logic [IDX_W-1:0] crow;
    logic [IDX_W-1:0] ccol;
    cell_t            cval;
    logic             err;
  } vec_t;

  vec_t vt [7];

  always #5 clk = ~clk;

  tablero_carga dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clear_req),
    .load_start (load_start),
    .cell_valid (cell_valid),
    .cell_data  (cell_data),
    .cell_ready (cell_ready),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .matriz     (matriz),
    .busy       (busy),
    .done       (done),
    .wr_err     (wr_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_board(input string name);
    int nd;
    nd = 0;
    n_cmp++;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (matriz[r][c] !== exp_b[r][c]) begin
          if (nd == 0)
            $display("FAIL %s: cell[%0d][%0d] got %0h want %0h",
                     name, r, c, matriz[r][c], exp_b[r][c]);
          nd++;
        end
    if (nd != 0) n_bad++;
  endtask

  task automatic set_pattern(input int base);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_b[r][c] = cell_t'(base + r * COLS + c);
  endtask

  task automatic set_clear;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_b[r][c] = CLEAR_VAL;
  endtask

  // Streams 25 cells base..base+24; lat counts cycles from the start pulse to done.
  task automatic run_load(input int base, input bit toggle, output int lat);
    int k;
    bit early;
    bit rdy_low;
    k = 0; lat = 0; early = 0; rdy_low = 0;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    while (k < ROWS * COLS && lat < 200) begin
      cell_valid = toggle ? !lat[0] : 1'b1;
      cell_data  = cell_t'(base + k);
      if (toggle && lat == 3) begin
        wr_en = 1'b1; wr_row = '0; wr_col = '0; wr_data = 8'hEE;
      end
      if (cell_valid) k++;
      tick;
      lat++;
      if (wr_en) begin
        wr_en = 1'b0;
        chk("wr_in_load_err", wr_err, 1);
      end
      if (k < ROWS * COLS) begin
        if (done) early = 1'b1;
        if (!cell_ready) rdy_low = 1'b1;
      end
    end
    cell_valid = 1'b0;
    chk("load_no_early_done", early, 0);
    chk("load_ready_held", rdy_low, 0);
    chk("load_done", done, 1);
    chk("load_ready_drop", cell_ready, 0);
    chk("load_busy_drop", busy, 0);
    tick;
    chk("load_done_one_cycle", done, 0);
  endtask

  // Watches a sweep already started; optionally pokes load_start mid-sweep.
  task automatic wait_sweep(input bit poke_load, output int first, output int ndone);
    first = 0; ndone = 0;
    for (int i = 1; i <= 30; i++) begin
      if (poke_load && i == 5) load_start = 1'b1;
      tick;
      load_start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) first = i;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat1, lat2, first, ndone;

    vt[0] = '{1'b1, 3'd3, 3'd1, 8'hAA, 3'd3, 3'd1, 8'hAA, 1'b0};
    vt[1] = '{1'b1, 3'd5, 3'd0, 8'h55, 3'd3, 3'd1, 8'hAA, 1'b1};
    vt[2] = '{1'b1, 3'd0, 3'd5, 8'h77, 3'd0, 3'd0, 8'h00, 1'b1};
    vt[3] = '{1'b1, 3'd4, 3'd4, 8'h3C, 3'd4, 3'd4, 8'h3C, 1'b0};
    vt[4] = '{1'b1, 3'd7, 3'd7, 8'h11, 3'd4, 3'd4, 8'h3C, 1'b1};
    vt[5] = '{1'b1, 3'd0, 3'd0, 8'h5A, 3'd0, 3'd0, 8'h5A, 1'b0};
    vt[6] = '{1'b0, 3'd0, 3'd0, 8'hFF, 3'd0, 3'd0, 8'h5A, 1'b0};

    // Reset and idle
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick;
    set_clear;
    chk_board("reset_board");
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", cell_ready, 0);
    chk("reset_wr_err", wr_err, 0);

    // Single-cell writes in IDLE
    for (int i = 0; i < 7; i++) begin
      wr_en = vt[i].en; wr_row = vt[i].row; wr_col = vt[i].col; wr_data = vt[i].data;
      tick;
      wr_en = 1'b0;
      chk($sformatf("vec%0d_cell", i), matriz[vt[i].crow][vt[i].ccol], vt[i].cval);
      chk($sformatf("vec%0d_err", i), wr_err, vt[i].err);
    end
    exp_b[3][1] = 8'hAA;
    exp_b[4][4] = 8'h3C;
    exp_b[0][0] = 8'h5A;
    chk_board("idle_writes_board");

    // Continuous load
    run_load(1, 1'b0, lat1);
    chk("cont_latency", lat1, 25);
    chk("cont_cell00", matriz[0][0], 8'h01);
    chk("cont_cell23", matriz[2][3], 8'h0E);
    chk("cont_cell44", matriz[4][4], 8'h19);
    set_pattern(1);
    chk_board("cont_board");

    // Plain clear sweep
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    chk("clear_busy", busy, 1);
    chk("clear_ready_low", cell_ready, 0);
    wait_sweep(1'b0, first, ndone);
    chk("clear_latency", first, 25);
    chk("clear_done_count", ndone, 1);
    set_clear;
    chk_board("clear_board");

    // Stalled load with a rejected write on a stall cycle
    run_load(1, 1'b1, lat2);
    chk("toggle_latency_delta", lat2 - lat1, 24);
    set_pattern(1);
    chk_board("toggle_board");

    // Abort after 10 cells
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cell_valid = 1'b1;
      cell_data  = cell_t'(8'h80 + k);
      tick;
    end
    clear_req = 1'b1; cell_valid = 1'b1; cell_data = 8'hFF;
    tick;
    clear_req = 1'b0; cell_valid = 1'b0;
    chk("abort_no_done", done, 0);
    chk("abort_ready_low", cell_ready, 0);
    chk("abort_busy", busy, 1);
    chk("abort_cell14", matriz[1][4], 8'h89);
    chk("abort_cell20_kept", matriz[2][0], 8'h0B);
    wait_sweep(1'b0, first, ndone);
    chk("abort_clear_latency", first, 25);
    chk("abort_done_count", ndone, 1);
    set_clear;
    chk_board("abort_board");

    // Simultaneous clear_req/load_start with a write in the same cycle
    wr_en = 1'b1; wr_row = 3'd1; wr_col = 3'd1; wr_data = 8'h66;
    clear_req = 1'b1; load_start = 1'b1;
    tick;
    wr_en = 1'b0; clear_req = 1'b0; load_start = 1'b0;
    chk("simul_wr_err", wr_err, 1);
    chk("simul_cell11", matriz[1][1], 8'h00);
    chk("simul_ready_low", cell_ready, 0);
    chk("simul_busy", busy, 1);
    wait_sweep(1'b1, first, ndone);
    chk("simul_latency", first, 25);
    chk("simul_done_count", ndone, 1);
    chk("simul_idle_busy", busy, 0);
    chk("simul_idle_ready", cell_ready, 0);

    // Reset in the middle of a load
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cell_valid = 1'b1;
      cell_data  = cell_t'(8'h40 + k);
      if (k == 6) begin
        wr_en = 1'b1; wr_row = 3'd4; wr_col = 3'd4; wr_data = 8'h99;
      end
      tick;
    end
    cell_valid = 1'b0; wr_en = 1'b0;
    chk("midload_ready", cell_ready, 1);
    chk("midload_wr_err", wr_err, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_ready", cell_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_err", wr_err, 0);
    set_clear;
    chk_board("rst_board");
    #1 rst_n = 1'b1;
    tick;
    run_load(8'h60, 1'b0, lat1);
    chk("post_rst_latency", lat1, 25);
    set_pattern(8'h60);
    chk_board("post_rst_board");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
